affine_interp_ctrl_8: RTL and testbench
=======================================

AFFINE_INTERP_CTRL_8 -- requirements
Module: affine_interp_ctrl_8

Interface
REQ-001 Parameters: ROW_MAX, 64, maximum row length in samples; SUM_W, 18, width of the filter-sum input.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle row request; sampled only in IDLE.
REQ-005 row_len  in  7  samples in the row, legal range 8..ROW_MAX; latched on accepted start.
REQ-006 phase  in  4  fractional position, 1/16 units; latched on accepted start.
REQ-007 in_valid / in_ready  in / out  1 / 1  sample handshake; a transfer occurs when both are high.
REQ-008 in_data  in  8  signed input sample.
REQ-009 win_x0..win_x7  out  8 each  signed 8-tap window presented to the external tap MCM bank; win_x3 is the integer position.
REQ-010 win_phase  out  4  latched phase, selecting the MCM output of each tap.
REQ-011 filt_sum  in  SUM_W  signed sum of the 8 tap products, combinational from win_x*/win_phase in the same cycle.
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-013 out_data  out  8  signed interpolated sample.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse after the last output transfer.

Function
REQ-016 FSM states: IDLE, PRIME, RUN, FLUSH, DONE.
REQ-017 IDLE: start=1 latches row_len and phase, clears all counters, and moves to PRIME; start is ignored in every other state.
REQ-018 PRIME, first transfer: sample s0 is written to w0..w3.
REQ-019 PRIME, transfers s1..s4: written to w4..w7 in order; after s4 the window is valid for output n=0 and the FSM moves to RUN.
REQ-020 Output n always uses samples n-3..n+4 in w0..w7.
REQ-021 Left padding: indices below 0 use s0.
REQ-022 Right padding: indices above row_len-1 use s[row_len-1].
REQ-023 Output slot free condition: out_valid=0, or (out_valid=1 and out_ready=1).
REQ-024 Advance condition: window valid, output slot free, and either (a) the next sample transfers this cycle (RUN) or (b) all row_len samples are already consumed (FLUSH).
REQ-025 Advance actions, all in the same cycle: out_data is registered, out_valid=1, the window shifts (wi <= wi+1), and w7 takes the new sample (RUN) or w7 (FLUSH).
REQ-026 in_ready=1 only in PRIME, or in RUN when the output slot is free; in_ready=0 in IDLE, FLUSH and DONE.
REQ-027 RUN moves to FLUSH on the cycle sample s[row_len-1] is accepted.
REQ-028 FLUSH continues advancing until row_len outputs have been produced.
REQ-029 out_valid holds and out_data is stable while out_ready=0; no output is dropped or duplicated.
REQ-030 After the last output transfers, the FSM enters DONE: done=1 for one cycle, then IDLE.
REQ-031 phase=0: out_data = w3, bypassing filt_sum.
REQ-032 phase≠0: out_data = sat8((filt_sum + 32) >>> 6), arithmetic shift; saturation to -128..127.
REQ-033 Latency: first out_valid is asserted the cycle after the first RUN advance; that advance can occur no earlier than the cycle after s4 is accepted.
REQ-034 Throughput: one output per cycle when in_valid=1 and out_ready=1 continuously.
REQ-035 Output and sample counters are 7 bits and never wrap within a row.
REQ-036 An out_ready transfer and a new advance in the same cycle replace out_data without a bubble.

Reset
REQ-037 rst=1 forces: IDLE; w0..w7=0; counters=0; out_valid=0; out_data=0; in_ready=0; busy=0; done=0; latched phase=0; latched row_len=0.
REQ-038 Reset mid-row abandons the row; no done pulse is issued, and no output appears until the next start.

Structure
REQ-039 Shared package interp_pkg holds the state enum, TAPS=8, FRAC_BITS=4, COEF_SHIFT=6, ROUND=32 and the SAT_MIN/SAT_MAX constants.
REQ-040 Rounding/saturation is one sub-module, interp_round_sat; the MCM tap bank stays external to this block.

Verification
REQ-041 Constant row: row_len=10, all samples 20, phase=8, bench returns filt_sum=64*20 -> ten outputs of 20, then one done pulse.
REQ-042 Phase bypass: row_len=8, samples 0..7, phase=0 -> outputs 0,1,2,3,4,5,6,7.
REQ-043 Padding check: row_len=8, samples 0..7 -> window at n=0 is 0,0,0,0,1,2,3,4 and window at n=7 is 4,5,6,7,7,7,7,7.
REQ-044 Saturation and rounding: phase=5; filt_sum=9000 -> 127; filt_sum=-9000 -> -128; filt_sum=95 -> 1; filt_sum=96 -> 2.
REQ-045 Backpressure: random out_ready and in_valid gaps on a 64-sample row -> exactly 64 ordered outputs, each stable while stalled.
REQ-046 Reset mid-row: rst asserted after 12 outputs of a 64-sample row -> all outputs zero and IDLE next cycle; no done pulse; a new row then runs correctly.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared types and constants for the affine interpolation controller.
package interp_pkg;

    localparam int TAPS       = 8;
    localparam int FRAC_BITS  = 4;
    localparam int COEF_SHIFT = 6;
    localparam int ROUND      = 32;

    localparam logic signed [7:0] SAT_MIN = 8'sh80;
    localparam logic signed [7:0] SAT_MAX = 8'sh7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/interp_round_sat.sv
// Rounds the filter sum back to sample scale and saturates it to 8 bits.
module interp_round_sat
    import interp_pkg::*;
#(
    parameter int SUM_W = 18
) (
    input  logic signed [SUM_W-1:0] sum,
    output logic signed [7:0]       y
);

    logic signed [SUM_W:0] rounded;
    logic signed [SUM_W:0] shifted;

    always_comb begin
        rounded = {sum[SUM_W-1], sum} + (SUM_W+1)'(ROUND);
        shifted = rounded >>> COEF_SHIFT;
        // In range when every bit above bit 7 repeats the 8-bit sign.
        if (shifted[SUM_W:7] == {(SUM_W-6){shifted[7]}}) begin
            y = shifted[7:0];
        end else if (shifted[SUM_W]) begin
            y = SAT_MIN;
        end else begin
            y = SAT_MAX;
        end
    end

endmodule

// File: rtl/affine_interp_ctrl_8.sv
// Row controller for an 8-tap interpolator: primes the window, streams one
// output per accepted sample, then flushes with right-edge padding.
//
// state | meaning
// IDLE  | waiting for start
// PRIME | loading s0..s4 into the window
// RUN   | one advance per accepted sample
// FLUSH | all samples consumed, advancing on the padded window
// DONE  | one-cycle done pulse
module affine_interp_ctrl_8
    import interp_pkg::*;
#(
    parameter int ROW_MAX = 64,
    parameter int SUM_W   = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [6:0]              row_len,
    input  logic [3:0]              phase,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [7:0]       in_data,
    output logic signed [7:0]       win_x0,
    output logic signed [7:0]       win_x1,
    output logic signed [7:0]       win_x2,
    output logic signed [7:0]       win_x3,
    output logic signed [7:0]       win_x4,
    output logic signed [7:0]       win_x5,
    output logic signed [7:0]       win_x6,
    output logic signed [7:0]       win_x7,
    output logic [3:0]              win_phase,
    input  logic signed [SUM_W-1:0] filt_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [7:0]       out_data,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = $clog2(ROW_MAX + 1);

    state_t                 state_q, state_d;
    logic signed [7:0]      win_q [TAPS];
    logic signed [7:0]      win_d [TAPS];
    logic [CNT_W-1:0]       in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]       row_len_q, row_len_d;
    logic [FRAC_BITS-1:0]   phase_q, phase_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [7:0]      out_data_q, out_data_d;
    logic                   slot_free;
    logic                   advance;
    logic signed [7:0]      rs_y;

    interp_round_sat #(.SUM_W(SUM_W)) u_round_sat (
        .sum (filt_sum),
        .y   (rs_y)
    );

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        row_len_d   = row_len_q;
        phase_d     = phase_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready    = 1'b0;
        advance     = 1'b0;
        slot_free   = !out_valid_q || out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_len_d = row_len;
                    phase_d   = phase;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = ST_PRIME;
                end
            end
            ST_PRIME: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    case (in_cnt_q)
                        CNT_W'(0): begin
                            for (int i = 0; i < 4; i++) win_d[i] = in_data;
                        end
                        CNT_W'(1): win_d[4] = in_data;
                        CNT_W'(2): win_d[5] = in_data;
                        CNT_W'(3): win_d[6] = in_data;
                        default: begin
                            win_d[7] = in_data;
                            state_d  = ST_RUN;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    advance  = 1'b1;
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_q == row_len_q - CNT_W'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (out_cnt_q == row_len_q) begin
                    if (slot_free) state_d = ST_DONE;
                end else if (slot_free) begin
                    advance = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // The window shown this cycle is the one for the output being registered.
        if (advance) begin
            out_valid_d = 1'b1;
            out_data_d  = (phase_q == '0) ? win_q[3] : rs_y;
            out_cnt_d   = out_cnt_q + CNT_W'(1);
            for (int i = 0; i < TAPS-1; i++) win_d[i] = win_q[i+1];
            win_d[TAPS-1] = (state_q == ST_RUN) ? in_data : win_q[TAPS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_q       <= '{default: '0};
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            row_len_q   <= '0;
            phase_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            row_len_q   <= row_len_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign win_x0    = win_q[0];
    assign win_x1    = win_q[1];
    assign win_x2    = win_q[2];
    assign win_x3    = win_q[3];
    assign win_x4    = win_q[4];
    assign win_x5    = win_q[5];
    assign win_x6    = win_q[6];
    assign win_x7    = win_q[7];
    assign win_phase = phase_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_affine_interp_ctrl_8.sv
// Bench for affine_interp_ctrl_8: acts as the MCM tap bank and checks each
// row against a padded-window reference built from the sample array.
module tb_affine_interp_ctrl_8;

    localparam int SUM_W = 18;

    logic                    clk = 1'b0;
    logic                    rst, start, in_valid, out_ready;
    logic [6:0]              row_len;
    logic [3:0]              phase, win_phase;
    logic signed [7:0]       in_data, out_data;
    logic signed [7:0]       win_x0, win_x1, win_x2, win_x3, win_x4, win_x5, win_x6, win_x7;
    logic signed [SUM_W-1:0] filt_sum;
    logic                    in_ready, out_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int fmode  = 0;
    int fval   = 0;
    int smp [64];
    int mcm_acc;
    logic signed [7:0] wnow [8];
    int sat_v [4] = '{9000, -9000, 95, 96};

    always #5 clk = ~clk;

    affine_interp_ctrl_8 #(.ROW_MAX(64), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len), .phase(phase),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_x0(win_x0), .win_x1(win_x1), .win_x2(win_x2), .win_x3(win_x3),
        .win_x4(win_x4), .win_x5(win_x5), .win_x6(win_x6), .win_x7(win_x7),
        .win_phase(win_phase), .filt_sum(filt_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    // Arbitrary signed per-phase tap weights standing in for the MCM bank.
    function automatic int coef(int p, int k);
        return ((p * 7 + k * 13) % 23) - 5;
    endfunction

    always_comb begin
        wnow[0] = win_x0; wnow[1] = win_x1; wnow[2] = win_x2; wnow[3] = win_x3;
        wnow[4] = win_x4; wnow[5] = win_x5; wnow[6] = win_x6; wnow[7] = win_x7;
    end

    always_comb begin
        mcm_acc = 0;
        for (int k = 0; k < 8; k++) mcm_acc += coef(int'(win_phase), k) * int'(wnow[k]);
        filt_sum = (fmode != 0) ? SUM_W'(fval) : SUM_W'(mcm_acc);
    end

    function automatic int exp_win(int n, int k, int len);
        int idx = n - 3 + k;
        if (idx < 0) idx = 0;
        if (idx > len - 1) idx = len - 1;
        return smp[idx];
    endfunction

    function automatic int exp_out(int n, int len, int ph);
        int s = 0;
        int q;
        if (ph == 0) return exp_win(n, 3, len);
        if (fmode != 0) s = fval;
        else for (int k = 0; k < 8; k++) s += coef(ph, k) * exp_win(n, k, len);
        q = s + 32;
        q = (q >= 0) ? q / 64 : -((-q + 63) / 64);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) smp[i] = int'($urandom_range(255)) - 128;
    endtask

    task automatic run_row(input int len, input int ph, input int vp, input int rp,
                           input int abort_at, input bit chk_lat);
        int sent = 0, got = 0, nout = 0, cyc = 0, first = -1, last = -1;
        logic pv = 1'b0, pf = 1'b0;
        logic signed [7:0] pd = '0;
        logic signed [7:0] pw [8];
        bit fin = 1'b0;
        @(negedge clk);
        start = 1'b1; row_len = 7'(len); phase = 4'(ph); in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("win_phase_latched", win_phase, ph);
        while (!fin && cyc < 3000) begin
            if (abort_at > 0 && got >= abort_at) begin
                rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_win_x3", win_x3, 0);
                chk("rst_win_x7", win_x7, 0);
                chk("rst_win_phase", win_phase, 0);
                repeat (5) begin
                    @(negedge clk);
                    chk("rst_quiet", {done, out_valid, busy}, 0);
                end
                return;
            end
            if (out_valid && (!pv || pf)) begin
                chk("no_extra_output", nout < len, 1);
                for (int k = 0; k < 8; k++) chk($sformatf("win%0d_n%0d", k, nout), pw[k], exp_win(nout, k, len));
                chk($sformatf("out_data_n%0d", nout), out_data, exp_out(nout, len, ph));
                if (first < 0) first = cyc;
                last = cyc;
                nout++;
            end else if (pv && !pf) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
            end
            if (done) begin
                chk("done_after_all", got, len);
                chk("done_nout", nout, len);
                fin = 1'b1;
            end else begin
                in_valid  = (sent < len) && ($urandom_range(99) < vp);
                in_data   = (sent < len) ? 8'(smp[sent]) : 8'sd0;
                out_ready = ($urandom_range(99) < rp);
                start     = 1'($urandom_range(1));
                #1;
                pv = out_valid; pf = out_valid && out_ready; pd = out_data; pw = wnow;
                if (in_valid && in_ready) sent++;
                if (pf) got++;
                @(negedge clk);
                cyc++;
            end
        end
        chk("row_finished", fin, 1);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        if (chk_lat) begin
            chk("first_out_latency", first, 6);
            chk("full_throughput", last - first, len - 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; row_len = '0; phase = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_win_x0", win_x0, 0);
        chk("reset_win_x7", win_x7, 0);
        chk("reset_win_phase", win_phase, 0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) smp[i] = 20;
        fmode = 1; fval = 64 * 20;
        run_row(10, 8, 100, 100, 0, 1);

        for (int i = 0; i < 64; i++) smp[i] = i;
        fmode = 0;
        run_row(8, 0, 100, 100, 0, 1);
        run_row(8, 3, 60, 60, 0, 0);

        fmode = 1;
        foreach (sat_v[i]) begin
            fval = sat_v[i];
            run_row(8, 5, 100, 100, 0, 0);
        end
        fmode = 0;

        repeat (4) begin
            fill_random();
            run_row(int'($urandom_range(8, 64)), int'($urandom_range(15)),
                    int'($urandom_range(40, 100)), int'($urandom_range(40, 100)), 0, 0);
        end

        fill_random();
        run_row(64, 11, 60, 50, 0, 0);

        fill_random();
        run_row(64, 6, 80, 70, 12, 0);
        fill_random();
        run_row(20, 9, 100, 100, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
